// File: rtl/ahb_rr_arbiter_pkg.sv
// Shared AHB encodings, arbiter FSM states and burst-length helper for ahb_rr_arbiter.
// Default system sizing: nine masters, 4-bit HMASTER.
package ahb_rr_arbiter_pkg;

  localparam int master_number = 9;
  localparam int size_out      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } transfer_t;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } burst_t;

  typedef enum {ARB, BURST, LOCK} arb_state_t;

  // Undefined-length INCR is treated like SINGLE: nothing to hold the grant for.
  function automatic logic [4:0] burst_beats(burst_t b);
    case (b)
      WRAP4, INCR4:   return 5'd4;
      WRAP8, INCR8:   return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:        return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first requester after i_last, wrapping back to i_last.
// o_valid is low when nobody requests; o_winner is then zero and must be ignored.
module rr_picker #(
  parameter int N_MASTERS = 9,
  parameter int MW        = 4
) (
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [MW-1:0]        i_last,
  output logic [MW-1:0]        o_winner,
  output logic                 o_valid
);

  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    // Upper segment first (above i_last), then wrap to 0 .. i_last.
    for (int i = 0; i < N_MASTERS; i++) begin
      if (!o_valid && i_req[i] && (i > int'(i_last))) begin
        o_valid  = 1'b1;
        o_winner = MW'(i);
      end
    end
    for (int i = 0; i < N_MASTERS; i++) begin
      if (!o_valid && i_req[i] && (i <= int'(i_last))) begin
        o_valid  = 1'b1;
        o_winner = MW'(i);
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// AHB round-robin bus arbiter: registered one-hot grant, HMASTER follows grant on HREADY,
// grant held for fixed-length bursts and locked sequences.
module ahb_rr_arbiter
  import ahb_rr_arbiter_pkg::*;
#(
  parameter int N_MASTERS      = master_number,
  parameter int MW             = size_out,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [N_MASTERS-1:0] HBUSREQ,
  input  logic [N_MASTERS-1:0] HLOCK,
  input  logic [1:0]           HTRANS,
  input  logic [2:0]           HBURST,
  input  logic                 HREADY,
  output logic [N_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]        HMASTER,
  output logic                 HMASTLOCK
);

  localparam logic [MW-1:0]        DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [N_MASTERS-1:0] ONE     = {{(N_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [N_MASTERS-1:0] DEF_OH  = ONE << DEFAULT_MASTER;

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;
  logic [N_MASTERS-1:0] r_grant;
  logic [MW-1:0]        r_gidx;
  logic [MW-1:0]        r_master;
  logic                 r_mastlock;

  logic [MW-1:0]        w_pick;
  logic                 w_pick_vld;
  logic [MW-1:0]        w_win_idx;
  logic [N_MASTERS-1:0] w_win_oh;
  logic                 w_grant_upd;
  logic [4:0]           w_beats;
  logic                 w_own_lock;
  logic                 w_idle;
  logic                 w_seq;
  logic                 w_nonseq;

  // The rotation pointer is the current grantee, so a full request vector advances every cycle.
  rr_picker #(
    .N_MASTERS (N_MASTERS),
    .MW        (MW)
  ) u_picker (
    .i_req    (HBUSREQ),
    .i_last   (r_gidx),
    .o_winner (w_pick),
    .o_valid  (w_pick_vld)
  );

  assign w_win_idx  = w_pick_vld ? w_pick : DEF_IDX;
  assign w_win_oh   = ONE << w_win_idx;
  assign w_beats    = burst_beats(burst_t'(HBURST));
  assign w_own_lock = HLOCK[r_master];
  assign w_idle     = (HTRANS == IDLE);
  assign w_seq      = (HTRANS == SEQ);
  assign w_nonseq   = (HTRANS == NONSEQ);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ARB;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ARB: begin
        if (HREADY && w_nonseq) begin
          if (w_own_lock) begin
            w_state_nxt = LOCK;
          end else if (w_beats != 5'd1) begin
            w_state_nxt = BURST;
            w_cnt_nxt   = 4'(w_beats - 5'd1);
          end
        end
      end
      BURST: begin
        // BUSY and wait states leave the remaining-beat count untouched.
        if (HREADY) begin
          if (w_seq) begin
            if (r_cnt <= 4'd1) begin
              w_state_nxt = ARB;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt - 4'd1;
            end
          end else if (w_idle || w_nonseq) begin
            w_state_nxt = ARB;
            w_cnt_nxt   = '0;
          end
        end
      end
      LOCK: begin
        if (HREADY && !w_own_lock) begin
          w_state_nxt = ARB;
        end
      end
      default: begin
        w_state_nxt = ARB;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Grant moves only on edges that leave (or stay in) ARB, so the edge that starts a
  // burst or lock keeps the current owner granted.
  always_comb begin
    w_grant_upd = (w_state_nxt == ARB);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_grant    <= DEF_OH;
      r_gidx     <= DEF_IDX;
      r_master   <= DEF_IDX;
      r_mastlock <= 1'b0;
    end else begin
      if (w_grant_upd) begin
        r_grant <= w_win_oh;
        r_gidx  <= w_win_idx;
      end
      if (HREADY) begin
        r_master   <= r_gidx;
        r_mastlock <= HLOCK[r_gidx];
      end
    end
  end

  assign HGRANT    = r_grant;
  assign HMASTER   = r_master;
  assign HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Bench for ahb_rr_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural ownership model.
module tb_ahb_rr_arbiter;
  import ahb_rr_arbiter_pkg::*;

  localparam int N = 9;

  logic       HCLK    = 1'b0;
  logic       HRESETn = 1'b0;
  logic [8:0] HBUSREQ = '0;
  logic [8:0] HLOCK   = '0;
  logic [1:0] HTRANS  = 2'b00;
  logic [2:0] HBURST  = 3'b000;
  logic       HREADY  = 1'b1;
  logic [8:0] HGRANT;
  logic [3:0] HMASTER;
  logic       HMASTLOCK;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Model: who is granted, who owns the address phase, and whether ownership is pinned.
  int m_gnt = 0;
  int m_mst = 0;
  bit m_lck = 1'b0;
  bit m_in_burst = 1'b0;
  bit m_in_lock  = 1'b0;
  int m_left = 0;
  int m_old_g = 0;

  ahb_rr_arbiter #(
    .N_MASTERS      (9),
    .MW             (4),
    .DEFAULT_MASTER (0)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  function automatic bit bit_at(input logic [8:0] v, input int i);
    return ((v >> i) & 9'd1) != 9'd0;
  endfunction

  function automatic int pick(input int last, input logic [8:0] req);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (bit_at(req, j)) return j;
    end
    return 0;
  endfunction

  function automatic int beats(input logic [2:0] b);
    if (b < 3'd2) return 1;
    return 4 << ((int'(b) - 2) / 2);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_gnt = 0; m_mst = 0; m_lck = 1'b0;
      m_in_burst = 1'b0; m_in_lock = 1'b0; m_left = 0;
    end else begin
      m_old_g = m_gnt;
      if (m_in_burst) begin
        if (HREADY) begin
          if (HTRANS == 2'b11) begin
            m_left = m_left - 1;
            if (m_left <= 0) begin m_in_burst = 1'b0; m_left = 0; end
          end else if (HTRANS == 2'b00 || HTRANS == 2'b10) begin
            m_in_burst = 1'b0; m_left = 0;
          end
        end
      end else if (m_in_lock) begin
        if (HREADY && !bit_at(HLOCK, m_mst)) m_in_lock = 1'b0;
      end else if (HREADY && HTRANS == 2'b10) begin
        if (bit_at(HLOCK, m_mst)) m_in_lock = 1'b1;
        else if (beats(HBURST) > 1) begin
          m_in_burst = 1'b1;
          m_left = beats(HBURST) - 1;
        end
      end
      if (!m_in_burst && !m_in_lock) m_gnt = pick(m_old_g, HBUSREQ);
      if (HREADY) begin
        m_lck = bit_at(HLOCK, m_old_g);
        m_mst = m_old_g;
      end
    end
  end

  always @(negedge HCLK) begin
    if (cmp_en) begin
      chk("cyc_hgrant", int'(HGRANT), int'(9'd1 << m_gnt));
      chk("cyc_hmaster", int'(HMASTER), m_mst);
      chk("cyc_hmastlock", int'(HMASTLOCK), int'(m_lck));
    end
  end

  task automatic drive(input logic [8:0] br, input logic [8:0] lk, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy);
    HBUSREQ = br; HLOCK = lk; HTRANS = tr; HBURST = bu; HREADY = rdy;
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge HCLK);
    #3 HRESETn = 1'b1;
    cmp_en = 1'b1;

    // Reset state, nobody requesting.
    chk("rst_hgrant", int'(HGRANT), 'h001);
    chk("rst_hmaster", int'(HMASTER), 0);
    chk("rst_hmastlock", int'(HMASTLOCK), 0);

    // Everyone requesting SINGLE: grant rotates every cycle, HMASTER one behind.
    for (int k = 1; k <= 10; k++) begin
      drive(9'h1FF, 9'h000, NONSEQ, SINGLE, 1'b1);
      chk("rot_hgrant", int'(HGRANT), 1 << (k % 9));
      chk("rot_hmaster", int'(HMASTER), (k - 1) % 9);
    end

    // M3 takes the bus, then INCR4 with M5 waiting; BUSY and wait states stretch the hold.
    drive(9'h008, 9'h000, IDLE, SINGLE, 1'b1);
    drive(9'h008, 9'h000, IDLE, SINGLE, 1'b1);
    chk("m3_own", int'(HMASTER), 3);
    drive(9'h028, 9'h000, NONSEQ, INCR4, 1'b1);
    chk("incr4_nonseq", int'(HGRANT), 'h008);
    drive(9'h028, 9'h000, SEQ, INCR4, 1'b1);
    drive(9'h028, 9'h000, BUSY, INCR4, 1'b1);
    drive(9'h028, 9'h000, SEQ, INCR4, 1'b0);
    drive(9'h028, 9'h000, SEQ, INCR4, 1'b0);
    chk("incr4_wait", int'(HGRANT), 'h008);
    drive(9'h028, 9'h000, SEQ, INCR4, 1'b1);
    chk("incr4_seq2", int'(HGRANT), 'h008);
    drive(9'h028, 9'h000, SEQ, INCR4, 1'b1);
    chk("incr4_last", int'(HGRANT), 'h020);
    chk("incr4_last_mst", int'(HMASTER), 3);

    // M2 locked sequence with every master requesting.
    drive(9'h004, 9'h004, IDLE, SINGLE, 1'b1);
    drive(9'h004, 9'h004, IDLE, SINGLE, 1'b1);
    for (int k = 0; k < 6; k++) begin
      drive(9'h1FF, 9'h004, NONSEQ, SINGLE, 1'b1);
      chk("lock_hgrant", int'(HGRANT), 'h004);
      chk("lock_hmastlock", int'(HMASTLOCK), 1);
    end
    drive(9'h1FF, 9'h000, NONSEQ, SINGLE, 1'b1);
    chk("unlock_hgrant", int'(HGRANT), 'h008);
    chk("unlock_hmastlock", int'(HMASTLOCK), 0);

    // M4 INCR8 terminated early by NONSEQ after two SEQ; M6 picks up at that edge.
    drive(9'h010, 9'h000, IDLE, SINGLE, 1'b1);
    drive(9'h010, 9'h000, IDLE, SINGLE, 1'b1);
    drive(9'h050, 9'h000, NONSEQ, INCR8, 1'b1);
    drive(9'h050, 9'h000, SEQ, INCR8, 1'b1);
    drive(9'h050, 9'h000, SEQ, INCR8, 1'b1);
    chk("incr8_hold", int'(HGRANT), 'h010);
    drive(9'h050, 9'h000, NONSEQ, SINGLE, 1'b1);
    chk("incr8_early", int'(HGRANT), 'h040);

    // Reset in the middle of an INCR16 owned by M7.
    drive(9'h080, 9'h000, IDLE, SINGLE, 1'b1);
    drive(9'h080, 9'h000, IDLE, SINGLE, 1'b1);
    drive(9'h180, 9'h000, NONSEQ, INCR16, 1'b1);
    for (int k = 0; k < 3; k++) drive(9'h180, 9'h000, SEQ, INCR16, 1'b1);
    chk("incr16_hold", int'(HGRANT), 'h080);
    chk("incr16_mst", int'(HMASTER), 7);
    #2 HRESETn = 1'b0;
    #1;
    chk("midrst_hgrant", int'(HGRANT), 'h001);
    chk("midrst_hmaster", int'(HMASTER), 0);
    chk("midrst_hmastlock", int'(HMASTLOCK), 0);
    #3 HRESETn = 1'b1;
    drive(9'h180, 9'h000, IDLE, SINGLE, 1'b1);
    chk("post_rst_ptr", int'(HGRANT), 'h080);

    // Random traffic with occasional mid-cycle resets.
    for (int it = 0; it < 3000; it++) begin
      logic [8:0] br, lk;
      br = 9'($urandom_range(0, 511));
      lk = 9'($urandom_range(0, 511)) & 9'($urandom_range(0, 511)) & 9'($urandom_range(0, 511));
      drive(br, lk, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 199) == 0) begin
        #1 HRESETn = 1'b0;
        #2 HRESETn = 1'b1;
      end
    end

    @(posedge HCLK);
    #1;
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
